// File: rtl/lfsr_share_ctrl_if.sv
// Request/grant and seed-load signal bundle between random-number consumers and lfsr_share_ctrl.
interface lfsr_share_ctrl_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req;
  logic            seed_load;
  logic [7:0]      seed_val;
  logic [NREQ-1:0] gnt;
  logic [7:0]      rnd_data;
  logic            busy;

  modport master (
    output req, seed_load, seed_val,
    input  gnt, rnd_data, busy
  );

  modport slave (
    input  req, seed_load, seed_val,
    output gnt, rnd_data, busy
  );
endinterface

// File: rtl/lfsr_share_ctrl.sv
// Round-robin arbiter sharing one 8-bit Fibonacci LFSR; each grant advances it STEPS times.
// Optional LFSR_FREE_RUN_EN: LFSR also advances every idle cycle without seed_load.
module lfsr_share_ctrl #(
  parameter int         NREQ  = 4,
  parameter int         STEPS = 3,
  parameter logic [7:0] SEED  = 8'h01
) (
  input  logic              clk,
  input  logic              reset,
  lfsr_share_ctrl_if.slave  bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] STEP  = 2'd1;
  localparam logic [1:0] GRANT = 2'd2;

  logic [1:0]      state;
  logic [7:0]      lfsr;
  logic [3:0]      cnt;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   idx;
  logic            found;
  logic [NREQ-1:0] win_onehot;
  logic [NREQ-1:0] gnt;
  logic [7:0]      rnd_data;
  logic            busy;

  assign bus.gnt      = gnt;
  assign bus.rnd_data = rnd_data;
  assign bus.busy     = busy;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    if (v == 8'h00) return 8'h01;
    return {v[4] ^ v[3] ^ v[2] ^ v[0], v[7:1]};
  endfunction

  // First set request at or above ptr, wrapping past NREQ-1 back to 0.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = IW'((32'(ptr) + i) % NREQ);
      if (!found && bus.req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << winner;

  // busy is a flop loaded with the next-state decode so it never glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      lfsr     <= SEED;
      cnt      <= '0;
      winner   <= '0;
      ptr      <= '0;
      gnt      <= '0;
      rnd_data <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.seed_load) begin
            lfsr <= (bus.seed_val == 8'h00) ? 8'h01 : bus.seed_val;
          end else begin
`ifdef LFSR_FREE_RUN_EN
            lfsr <= lfsr_next(lfsr);
`else
            lfsr <= lfsr;
`endif
            if (found) begin
              winner <= pick;
              cnt    <= '0;
              state  <= STEP;
              busy   <= 1'b1;
            end
          end
        end
        STEP: begin
          lfsr <= lfsr_next(lfsr);
          if (cnt == 4'(STEPS - 1)) begin
            gnt      <= win_onehot;
            rnd_data <= lfsr_next(lfsr);
            state    <= GRANT;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        GRANT: begin
          gnt   <= '0;
          ptr   <= (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_share_ctrl.sv
// Self-checking bench for lfsr_share_ctrl: directed cases pinned to literals, then randomized traffic vs a model.
module tb_lfsr_share_ctrl;

  localparam int         NREQ  = 4;
  localparam int         STEPS = 3;
  localparam logic [7:0] SEED  = 8'h01;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lfsr_share_ctrl_if #(.NREQ(NREQ)) bus ();

  lfsr_share_ctrl #(.NREQ(NREQ), .STEPS(STEPS), .SEED(SEED)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int busy_cnt = 0;

  // Transaction-level model: on acceptance the granted value and the grant/idle cycles are computed up front.
  logic [7:0]      m_lfsr, m_rnd, m_val;
  logic [NREQ-1:0] m_gnt;
  logic            m_busy;
  int              m_ptr, m_win, m_grant_at, m_idle_at;

  function automatic logic [7:0] step(input logic [7:0] v);
    if (v == 8'h00) return 8'h01;
    return {v[4] ^ v[3] ^ v[2] ^ v[0], v[7:1]};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_lfsr = SEED;
    m_rnd  = 8'h00;
    m_gnt  = '0;
    m_busy = 1'b0;
    m_ptr  = 0;
    m_win  = 0;
  endtask

  task automatic model_update();
    bit found;
    if (m_busy) begin
      if (cyc == m_grant_at) begin
        m_gnt = NREQ'(1) << m_win;
        m_rnd = m_val;
      end else if (cyc == m_idle_at) begin
        m_gnt  = '0;
        m_ptr  = (m_win + 1) % NREQ;
        m_busy = 1'b0;
      end
    end else if (bus.seed_load) begin
      m_lfsr = (bus.seed_val == 8'h00) ? 8'h01 : bus.seed_val;
    end else begin
`ifdef LFSR_FREE_RUN_EN
      m_lfsr = step(m_lfsr);
`endif
      if (bus.req != '0) begin
        found = 0;
        for (int i = 0; i < NREQ; i++) begin
          int j;
          j = (m_ptr + i) % NREQ;
          if (!found && bus.req[j]) begin
            m_win = j;
            found = 1;
          end
        end
        for (int s = 0; s < STEPS; s++) m_lfsr = step(m_lfsr);
        m_val      = m_lfsr;
        m_grant_at = cyc + STEPS;
        m_idle_at  = cyc + STEPS + 1;
        m_busy     = 1'b1;
      end
    end
  endtask

  task automatic compare_outputs();
    chk("gnt", int'(bus.gnt), int'(m_gnt));
    chk("rnd_data", int'(bus.rnd_data), int'(m_rnd));
    chk("busy", int'(bus.busy), int'(m_busy));
    chk("gnt_onehot0", int'($onehot0(bus.gnt)), 1);
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    if (!reset) model_reset();
    else        model_update();
    @(negedge clk);
    compare_outputs();
    if (bus.busy) busy_cnt++;
  endtask

  task automatic wait_grant(output logic [NREQ-1:0] g, output logic [7:0] v);
    bit got;
    got = 0;
    g   = '0;
    v   = '0;
    for (int k = 0; k < 20 && !got; k++) begin
      cycle();
      if (bus.gnt != '0) begin
        got = 1;
        g   = bus.gnt;
        v   = bus.rnd_data;
      end
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL grant_timeout at cycle %0d: got no grant expected one within 20 cycles", cyc);
    end
  endtask

  logic [NREQ-1:0] g;
  logic [7:0]      v;
  logic [NREQ-1:0] rr_exp [5];
  int              last_cyc;

  initial begin
    reset         = 1'b0;
    bus.req       = '0;
    bus.seed_load = 1'b0;
    bus.seed_val  = 8'h00;
    model_reset();
    #1;
    chk("reset_gnt", int'(bus.gnt), 0);
    chk("reset_rnd", int'(bus.rnd_data), 0);
    chk("reset_busy", int'(bus.busy), 0);
    cycle();
    cycle();
    reset = 1'b1;

    // First grant after reset: 01 -> 80 -> 40 -> 20, busy for STEPS+1 cycles.
    busy_cnt = 0;
    bus.req  = 4'b0001;
    wait_grant(g, v);
    bus.req = '0;
    chk("first_gnt", int'(g), 4'b0001);
`ifndef LFSR_FREE_RUN_EN
    chk("first_val", int'(v), 8'h20);
`endif
    repeat (4) cycle();
    chk("busy_len", busy_cnt, STEPS + 1);

    bus.req = 4'b0001;
    wait_grant(g, v);
    bus.req = '0;
`ifndef LFSR_FREE_RUN_EN
    chk("second_val", int'(v), 8'hC4);
`endif
    repeat (3) cycle();

    // Seed load wins over a same-edge request.
    bus.seed_load = 1'b1;
    bus.seed_val  = 8'h10;
    bus.req       = 4'b0010;
    cycle();
    chk("seed_edge_busy", int'(bus.busy), 0);
    bus.seed_load = 1'b0;
    wait_grant(g, v);
    bus.req = '0;
    chk("seed_gnt", int'(g), 4'b0010);
`ifndef LFSR_FREE_RUN_EN
    chk("seed_val", int'(v), 8'hE2);
`endif
    repeat (3) cycle();

    // Zero seed maps to 01; seed_load during STEP is dropped.
    bus.seed_load = 1'b1;
    bus.seed_val  = 8'h00;
    cycle();
    bus.seed_load = 1'b0;
    bus.req       = 4'b0001;
    cycle();
    bus.seed_load = 1'b1;
    bus.seed_val  = 8'h55;
    cycle();
    bus.seed_load = 1'b0;
    wait_grant(g, v);
    bus.req = '0;
`ifndef LFSR_FREE_RUN_EN
    chk("zero_seed_val", int'(v), 8'h20);
`endif
    repeat (3) cycle();

    // Reset in the middle of STEP aborts the grant and restores SEED and pointer.
    bus.req = 4'b0100;
    cycle();
    cycle();
    reset = 1'b0;
    model_reset();
    #1;
    chk("midrst_gnt", int'(bus.gnt), 0);
    chk("midrst_rnd", int'(bus.rnd_data), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    cycle();
    reset   = 1'b1;
    bus.req = 4'b0101;
    wait_grant(g, v);
    bus.req = '0;
    chk("postrst_gnt", int'(g), 4'b0001);
`ifndef LFSR_FREE_RUN_EN
    chk("postrst_val", int'(v), 8'h20);
`endif
    repeat (3) cycle();

    // All requesters held: rotation continues from requester 1.
    rr_exp[0] = 4'b0010;
    rr_exp[1] = 4'b0100;
    rr_exp[2] = 4'b1000;
    rr_exp[3] = 4'b0001;
    rr_exp[4] = 4'b0010;
    bus.req  = 4'b1111;
    last_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g, v);
      chk("rr_order", int'(g), int'(rr_exp[k]));
      if (k > 0) chk("rr_spacing", cyc - last_cyc, STEPS + 2);
      last_cyc = cyc;
    end
    bus.req = '0;
    repeat (3) cycle();

    // Randomized traffic checked every cycle against the model.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 3) == 0) bus.req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      bus.seed_load = ($urandom_range(0, 9) == 0);
      bus.seed_val  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 199) == 0) reset = 1'b0;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
